// File: rtl/engine_scheduler.sv
// engine_scheduler: walks a frame in raster order, issuing pixel batches to an engine bank
// and serializing the collected results onto a valid/ready stream with sop/eop framing.
module engine_scheduler #(
    parameter int PIXEL_DATA_WIDTH = 10,
    parameter int SCREEN_WIDTH     = 640,
    parameter int SCREEN_HEIGHT    = 480,
    parameter int NUM_ENGINES      = 12,
    parameter int RESULT_WIDTH     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    output logic [NUM_ENGINES-1:0]      eng_start,
    output logic [PIXEL_DATA_WIDTH-1:0] eng_x [NUM_ENGINES],
    output logic [PIXEL_DATA_WIDTH-1:0] eng_y [NUM_ENGINES],
    input  logic [NUM_ENGINES-1:0]      eng_done,
    input  logic [RESULT_WIDTH-1:0]     eng_result [NUM_ENGINES],
    output logic [RESULT_WIDTH-1:0]     out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic                        frame_done
);
    localparam int XW   = PIXEL_DATA_WIDTH;
    localparam int N    = NUM_ENGINES;
    localparam int W    = SCREEN_WIDTH;
    localparam int NPIX = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int PCW  = $clog2(NPIX);
    localparam int KW   = $clog2(NUM_ENGINES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    state_t                  state_q;
    logic [XW-1:0]           x0_q, y0_q;
    logic [PCW-1:0]          pix_q;
    logic [KW-1:0]           act_q, k_q;
    logic [N-1:0]            flag_q, start_q;
    logic                    fd_q;
    logic [RESULT_WIDTH-1:0] res_q [N];
    logic [XW-1:0]           ex_q [N];
    logic [XW-1:0]           ey_q [N];

    int                      adv_p, adv_x, nb_p, nb_x, nb_y, nact;
    logic                    frame_end, last_beat, issue_go, all_done;
    logic [N-1:0]            mask, flag_d, start_d;
    logic [XW-1:0]           ex_d [N];
    logic [XW-1:0]           ey_d [N];

    // Next batch base: advanced base mid-frame, (0,0) from IDLE or after the frame's last pixel.
    always_comb begin
        adv_p     = int'(pix_q) + int'(act_q);
        adv_x     = int'(x0_q) + int'(act_q);
        frame_end = adv_p == NPIX;
        nb_p      = (state_q == IDLE || frame_end) ? 0 : adv_p;
        nb_y      = (state_q == IDLE || frame_end) ? 0 : int'(y0_q) + (adv_x >= W ? 1 : 0);
        nb_x      = (state_q == IDLE || frame_end) ? 0 : (adv_x >= W ? adv_x - W : adv_x);
        nact      = (NPIX - nb_p < N) ? NPIX - nb_p : N;
        for (int i = 0; i < N; i++) begin
            mask[i]    = i < int'(act_q);
            start_d[i] = i < nact;
            ex_d[i]    = (i < nact) ? XW'(nb_x + i >= W ? nb_x + i - W : nb_x + i) : '0;
            ey_d[i]    = (i < nact) ? XW'(nb_x + i >= W ? nb_y + 1 : nb_y) : '0;
        end
        flag_d    = flag_q | (eng_done & mask);
        all_done  = (flag_d & mask) == mask;
        last_beat = state_q == DRAIN && out_ready && (k_q + 1'b1) == act_q;
        issue_go  = (state_q == IDLE && enable) || (last_beat && (!frame_end || enable));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            pix_q   <= '0;
            act_q   <= '0;
            k_q     <= '0;
            flag_q  <= '0;
            start_q <= '0;
            fd_q    <= 1'b0;
            res_q   <= '{default: '0};
            ex_q    <= '{default: '0};
            ey_q    <= '{default: '0};
        end else begin
            start_q <= '0;
            fd_q    <= 1'b0;
            case (state_q)
                ISSUE: begin
                    flag_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    flag_q <= flag_d;
                    for (int i = 0; i < N; i++)
                        if (eng_done[i] && mask[i] && !flag_q[i]) res_q[i] <= eng_result[i];
                    if (all_done) begin
                        state_q <= DRAIN;
                        k_q     <= '0;
                    end
                end
                DRAIN: if (out_ready) begin
                    k_q <= k_q + 1'b1;
                    if (last_beat) begin
                        x0_q    <= XW'(nb_x);
                        y0_q    <= XW'(nb_y);
                        pix_q   <= PCW'(nb_p);
                        fd_q    <= frame_end;
                        state_q <= IDLE;
                        ex_q    <= '{default: '0};
                        ey_q    <= '{default: '0};
                    end
                end
                default: ;
            endcase
            if (issue_go) begin
                state_q <= ISSUE;
                start_q <= start_d;
                ex_q    <= ex_d;
                ey_q    <= ey_d;
                act_q   <= KW'(nact);
            end
        end
    end

    assign eng_start  = start_q;
    assign eng_x      = ex_q;
    assign eng_y      = ey_q;
    assign frame_done = fd_q;
    assign out_valid  = state_q == DRAIN;
    assign out_data   = out_valid ? res_q[k_q] : '0;
    assign out_sop    = out_valid && pix_q == '0 && k_q == '0;
    assign out_eop    = out_valid && (int'(pix_q) + int'(k_q) == NPIX - 1);
endmodule

// File: tb/tb_engine_scheduler.sv
// tb_engine_scheduler: default-size instance for startup, 8x2/3-engine instance for
// row carry, partial batches, done ordering, backpressure, enable and reset behaviour.
module tb_engine_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst0, en0, rdy0, ov0, sop0, eop0, fd0;
    logic [11:0] start0, done0;
    logic [9:0]  ex0 [12];
    logic [9:0]  ey0 [12];
    logic [7:0]  res0 [12];
    logic [7:0]  od0;

    engine_scheduler d0 (
        .clk(clk), .reset(rst0), .enable(en0), .eng_start(start0), .eng_x(ex0), .eng_y(ey0),
        .eng_done(done0), .eng_result(res0), .out_data(od0), .out_valid(ov0), .out_ready(rdy0),
        .out_sop(sop0), .out_eop(eop0), .frame_done(fd0)
    );

    always_ff @(posedge clk) begin
        done0 <= start0;
        for (int i = 0; i < 12; i++) if (start0[i]) res0[i] <= ex0[i][7:0];
    end

    logic       rst1, en1, rdy1, ov1, sop1, eop1, fd1, auto1;
    logic [2:0] start1, done1, done1_auto, man_done;
    logic [9:0] ex1 [3];
    logic [9:0] ey1 [3];
    logic [7:0] res1 [3];
    logic [7:0] res1_auto [3];
    logic [7:0] man_res [3];
    logic [7:0] od1;

    engine_scheduler #(.PIXEL_DATA_WIDTH(10), .SCREEN_WIDTH(8), .SCREEN_HEIGHT(2),
                       .NUM_ENGINES(3), .RESULT_WIDTH(8)) d1 (
        .clk(clk), .reset(rst1), .enable(en1), .eng_start(start1), .eng_x(ex1), .eng_y(ey1),
        .eng_done(done1), .eng_result(res1), .out_data(od1), .out_valid(ov1), .out_ready(rdy1),
        .out_sop(sop1), .out_eop(eop1), .frame_done(fd1)
    );

    // Auto engines return the pixel's linear index one cycle after start.
    always_ff @(posedge clk) begin
        done1_auto <= start1 & {3{auto1}};
        for (int i = 0; i < 3; i++) if (start1[i]) res1_auto[i] <= 8'(int'(ey1[i]) * 8 + int'(ex1[i]));
    end
    assign done1 = done1_auto | man_done;
    always_comb for (int i = 0; i < 3; i++) res1[i] = auto1 ? res1_auto[i] : man_res[i];

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        int nz;
        rst0 = 1; rst1 = 1; en0 = 0; en1 = 0; rdy0 = 1; rdy1 = 1; auto1 = 1;
        man_done = '0; man_res = '{default: '0};
        repeat (3) tick();
        total++;
        if ({ov0, sop0, eop0, fd0, od0, start0} !== '0) begin
            bad++; $display("FAIL reset_d0 got=%h want=0", {ov0, sop0, eop0, fd0, od0, start0});
        end
        total++;
        if ({ov1, sop1, eop1, fd1, od1, start1} !== '0) begin
            bad++; $display("FAIL reset_d1 got=%h want=0", {ov1, sop1, eop1, fd1, od1, start1});
        end
        nz = 0;
        for (int i = 0; i < 12; i++) if (ex0[i] !== 0 || ey0[i] !== 0) nz++;
        for (int i = 0; i < 3; i++) if (ex1[i] !== 0 || ey1[i] !== 0) nz++;
        total++;
        if (nz != 0) begin bad++; $display("FAIL reset_coords nonzero=%0d want=0", nz); end
        rst0 = 0; rst1 = 0;
    endtask

    task automatic test_full_batch;
        int e;
        en0 = 1;
        tick();
        total++;
        if (start0 !== 12'hfff) begin bad++; $display("FAIL fb_start got=%h want=fff", start0); end
        e = 0;
        for (int i = 0; i < 12; i++) if (ex0[i] !== 10'(i) || ey0[i] !== 0) e++;
        total++;
        if (e != 0) begin bad++; $display("FAIL fb_coords bad_engines=%0d want=0", e); end
        tick();
        total++;
        if (ov0 !== 1'b0) begin bad++; $display("FAIL fb_wait_valid got=%b want=0", ov0); end
        tick();
        for (int i = 0; i < 12; i++) begin
            total++;
            if (ov0 !== 1'b1 || od0 !== 8'(i) || sop0 !== (i == 0)) begin
                bad++; $display("FAIL fb_beat%0d got v=%b d=%0d sop=%b want v=1 d=%0d sop=%b", i, ov0, od0, sop0, i, i == 0);
            end
            tick();
        end
        total++;
        if (start0 !== 12'hfff || ex0[0] !== 10'd12 || ex0[11] !== 10'd23 || ov0 !== 1'b0) begin
            bad++; $display("FAIL fb_batch2 got start=%h x0=%0d x11=%0d want fff 12 23", start0, ex0[0], ex0[11]);
        end
        en0 = 0; rst0 = 1;
        tick();
        rst0 = 0;
    endtask

    task automatic run_frame(input int pat, input int drop_at, output int beats, output int batches);
        int e, lin, wx, wy, idx;
        logic pstall, done_f;
        logic [7:0] pd;
        idx = 0; batches = 0; pstall = 0; done_f = 0; pd = '0;
        for (int c = 0; c < 400 && !done_f; c++) begin
            rdy1 = (pat == 0) ? 1'b1 : (c % 3 == 0);
            if (pstall) begin
                total++;
                if (ov1 !== 1'b1 || od1 !== pd) begin
                    bad++; $display("FAIL stall_hold got v=%b d=%0d want v=1 d=%0d", ov1, od1, pd);
                end
            end
            if (start1 !== '0) begin
                total++;
                if (start1 !== (batches < 5 ? 3'b111 : 3'b001)) begin
                    bad++; $display("FAIL batch%0d_start got=%b", batches, start1);
                end
                e = 0;
                for (int i = 0; i < 3; i++) begin
                    lin = batches * 3 + i;
                    wx = (lin < 16) ? lin % 8 : 0;
                    wy = (lin < 16) ? lin / 8 : 0;
                    if (ex1[i] !== 10'(wx) || ey1[i] !== 10'(wy)) e++;
                end
                total++;
                if (e != 0) begin bad++; $display("FAIL batch%0d_coords bad_engines=%0d want=0", batches, e); end
                if (batches == drop_at) en1 = 0;
                batches++;
            end
            if (ov1 && rdy1) begin
                total++;
                if (od1 !== 8'(idx) || sop1 !== (idx == 0) || eop1 !== (idx == 15)) begin
                    bad++; $display("FAIL beat%0d got d=%0d sop=%b eop=%b want d=%0d sop=%b eop=%b", idx, od1, sop1, eop1, idx, idx == 0, idx == 15);
                end
                idx++;
            end
            pstall = ov1 && !rdy1;
            pd = od1;
            tick();
            if (fd1) done_f = 1;
        end
        beats = idx;
        total++;
        if (!done_f) begin bad++; $display("FAIL frame_timeout got frame_done=0 want=1"); end
    endtask

    task automatic check_frame(input string name, input int beats, input int batches);
        total++;
        if (beats != 16 || batches != 6) begin
            bad++; $display("FAIL %s got beats=%0d batches=%0d want 16 6", name, beats, batches);
        end
    endtask

    task automatic test_row_carry;
        int b, n;
        rst1 = 1; tick(); rst1 = 0;
        auto1 = 1; en1 = 1;
        run_frame(0, -1, n, b);
        check_frame("row_carry", n, b);
    endtask

    task automatic test_enable;
        int b, n, nz;
        total++;
        if (start1 !== 3'b111 || ex1[0] !== 0 || ex1[1] !== 1 || ex1[2] !== 2 || ey1[2] !== 0) begin
            bad++; $display("FAIL restart_issue got start=%b x=%0d,%0d,%0d want 111 0,1,2", start1, ex1[0], ex1[1], ex1[2]);
        end
        run_frame(1, 2, n, b);
        check_frame("backpressure", n, b);
        nz = 0;
        for (int i = 0; i < 3; i++) if (ex1[i] !== 0 || ey1[i] !== 0) nz++;
        total++;
        if (start1 !== '0 || ov1 !== 1'b0 || nz != 0) begin
            bad++; $display("FAIL idle_after_drop got start=%b v=%b nzcoords=%0d want 0 0 0", start1, ov1, nz);
        end
        tick();
        total++;
        if (fd1 !== 1'b0) begin bad++; $display("FAIL frame_done_pulse got=%b want=0", fd1); end
        repeat (3) tick();
        total++;
        if (start1 !== '0 || ov1 !== 1'b0) begin bad++; $display("FAIL stays_idle got start=%b v=%b", start1, ov1); end
        en1 = 1;
        run_frame(0, -1, n, b);
        check_frame("reenable", n, b);
    endtask

    task automatic test_ooo;
        bit found;
        en1 = 0; rst1 = 1; tick(); rst1 = 0;
        auto1 = 0; en1 = 1; rdy1 = 1;
        tick();
        total++;
        if (start1 !== 3'b111) begin bad++; $display("FAIL ooo_start got=%b want=111", start1); end
        tick();
        man_done = 3'b100; man_res[2] = 8'hAA; tick();
        man_done = 3'b010; man_res[1] = 8'h22; tick();
        man_done = 3'b010; man_res[1] = 8'h33; tick();
        total++;
        if (ov1 !== 1'b0) begin bad++; $display("FAIL ooo_early_drain got v=%b want=0", ov1); end
        man_done = 3'b101; man_res[0] = 8'h11; man_res[2] = 8'h55; tick();
        man_done = '0;
        total++;
        if (ov1 !== 1'b1 || od1 !== 8'h11 || sop1 !== 1'b1) begin
            bad++; $display("FAIL ooo_beat0 got v=%b d=%h sop=%b want 1 11 1", ov1, od1, sop1);
        end
        tick();
        total++;
        if (od1 !== 8'h22) begin bad++; $display("FAIL ooo_beat1 got=%h want=22", od1); end
        tick();
        total++;
        if (od1 !== 8'hAA) begin bad++; $display("FAIL ooo_beat2 got=%h want=aa", od1); end
        tick();
        auto1 = 1;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) if (start1 === 3'b001) found = 1; else tick();
        total++;
        if (!found) begin bad++; $display("FAIL partial_batch_timeout got start=%b want=001", start1); end
        auto1 = 0; en1 = 0;
        tick();
        man_done = 3'b110; man_res[1] = 8'hEE; man_res[2] = 8'hEE; tick();
        total++;
        if (ov1 !== 1'b0) begin bad++; $display("FAIL inactive_done got v=%b want=0", ov1); end
        man_done = 3'b001; man_res[0] = 8'h5A; tick();
        man_done = '0;
        total++;
        if (ov1 !== 1'b1 || od1 !== 8'h5A || eop1 !== 1'b1 || sop1 !== 1'b0) begin
            bad++; $display("FAIL partial_beat got v=%b d=%h eop=%b sop=%b want 1 5a 1 0", ov1, od1, eop1, sop1);
        end
        tick();
        total++;
        if (fd1 !== 1'b1 || ov1 !== 1'b0) begin bad++; $display("FAIL ooo_frame_done got fd=%b v=%b want 1 0", fd1, ov1); end
        auto1 = 1;
    endtask

    task automatic test_reset_mid;
        int b, n, nz;
        bit found;
        auto1 = 0; en1 = 1;
        tick(); tick();
        rst1 = 1; tick();
        nz = 0;
        for (int i = 0; i < 3; i++) if (ex1[i] !== 0 || ey1[i] !== 0) nz++;
        total++;
        if (start1 !== '0 || ov1 !== 1'b0 || fd1 !== 1'b0 || nz != 0) begin
            bad++; $display("FAIL rst_wait got start=%b v=%b fd=%b nz=%0d want 0", start1, ov1, fd1, nz);
        end
        rst1 = 0; auto1 = 1;
        run_frame(0, -1, n, b);
        check_frame("after_rst_wait", n, b);
        rdy1 = 0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) if (ov1 === 1'b1) found = 1; else tick();
        total++;
        if (!found) begin bad++; $display("FAIL drain_timeout got v=%b want=1", ov1); end
        tick();
        rst1 = 1; tick();
        total++;
        if (start1 !== '0 || ov1 !== 1'b0 || od1 !== '0 || sop1 !== 1'b0) begin
            bad++; $display("FAIL rst_drain got start=%b v=%b d=%h sop=%b want 0", start1, ov1, od1, sop1);
        end
        rst1 = 0;
        run_frame(0, -1, n, b);
        check_frame("after_rst_drain", n, b);
        en1 = 0;
    endtask

    initial begin
        test_reset();
        test_full_batch();
        test_row_carry();
        test_enable();
        test_ooo();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/engine_scheduler.md
Name: engine_scheduler

Overview:
- Sequences a bank of NUM_ENGINES pixel engines through one full frame in raster order.
- Each batch runs in a fixed order: hand consecutive pixel coordinates to the engines, pulse start, collect each engine's result, then serialize the batch onto a valid/ready pixel stream in raster order.
- Sits between the per-pixel engines and the video output stream, replacing free-running coordinate distribution with an explicit issue/collect/drain handshake.

Parameters:
PIXEL_DATA_WIDTH, 10, width of x/y coordinates
SCREEN_WIDTH, 640, pixels per row (must be >= NUM_ENGINES)
SCREEN_HEIGHT, 480, rows per frame
NUM_ENGINES, 12, number of engines in the bank
RESULT_WIDTH, 8, width of each engine result (e.g. iteration count)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run request, sampled in IDLE and at frame end
eng_start  out  NUM_ENGINES  one-cycle start pulse per engine
eng_x  out  PIXEL_DATA_WIDTH x NUM_ENGINES  x coordinate per engine (unpacked array)
eng_y  out  PIXEL_DATA_WIDTH x NUM_ENGINES  y coordinate per engine (unpacked array)
eng_done  in  NUM_ENGINES  engine result valid (pulse or level)
eng_result  in  RESULT_WIDTH x NUM_ENGINES  engine result (unpacked array)
out_data  out  RESULT_WIDTH  pixel result, raster order
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts beat
out_sop  out  1  first pixel of frame (qualified by out_valid)
out_eop  out  1  last pixel of frame (qualified by out_valid)
frame_done  out  1  one-cycle pulse after last beat of frame accepted

Behaviour:
- Reset state:
  - All outputs 0; state IDLE.
  - Frame base (x0,y0) = (0,0).
  - Captured results and done flags cleared.
- Reset mid-operation: the same clear applies. Any engine start already issued is abandoned, and eng_done for it is ignored until the next ISSUE.
- States: IDLE, ISSUE, WAIT, DRAIN.
- Batch size:
  - active = min(NUM_ENGINES, pixels remaining in frame).
  - Only engines 0..active-1 participate.
  - The final batch may be partial when W*H is not a multiple of NUM_ENGINES.
- Coordinates:
  - engine i gets linear index base+i, i.e. x = (x0+i) mod W, y = y0 + (x0+i)/W.
  - At most one row carry per batch, since NUM_ENGINES <= W.
  - Coordinates for inactive engines = 0.
  - eng_x/eng_y are registered and held stable from the ISSUE cycle until WAIT exits.
- IDLE: if enable=1, go to ISSUE next cycle.
- ISSUE (one cycle):
  - eng_start[i]=1 for i < active, 0 otherwise.
  - Clear done flags; go to WAIT.
- WAIT:
  - On eng_done[i]=1 for an active i whose flag is clear, capture eng_result[i] and set the flag.
  - Later eng_done assertions for a set flag are ignored, so the first capture wins.
  - Inactive engines' eng_done are ignored.
  - When all active flags are set, including flags set in the same cycle, go to DRAIN next cycle.
- DRAIN:
  - Slot k counts 0..active-1.
  - out_valid=1, out_data = captured[k].
  - k advances only on out_valid & out_ready.
  - out_data/out_valid stay stable while stalled; no combinational path from out_ready to out_valid.
- Stream flags:
  - out_sop=1 only on slot 0 of the frame's first batch.
  - out_eop=1 only on the frame's final pixel.
- Batch end (last slot accepted):
  - Base advances by active, with row wrap and frame wrap to (0,0) after pixel W*H-1.
  - Not frame end: go to ISSUE (enable is not re-sampled mid-frame).
  - Frame end: frame_done=1 for one cycle; go to ISSUE if enable=1, else IDLE.
- Deasserting enable mid-frame has no effect until frame end.
- Throughput: with engines done the cycle after start and out_ready=1, a batch costs 1 (ISSUE) + 1 (WAIT min) + active (DRAIN) cycles.
- Arithmetic:
  - Pixel counter width = clog2(W*H).
  - No dividers or modulo operators on generic operands; use compare-and-subtract for the row carry.

Test Plan:
- Full-batch startup, defaults: reset, then enable=1; engines respond one cycle after start with result = x[7:0] -> first batch is eng_x 0..11, eng_y all 0; stream 0..11; out_sop on beat 0 only.
- Row carry and partial final batch, W=8, H=2, N=3:
  - Run one frame -> 6 batches of sizes 3,3,3,3,3,1.
  - Batch 3 coords (6,0),(7,0),(0,1).
  - Final batch starts only engine 0 at (7,1); out_eop on beat 16; frame_done pulses once.
- Out-of-order, late and duplicate done:
  - Engine 2 done first with 0xAA, engine 0 with 0x11, engine 1 done twice (0x22 then 0x33) -> stream 0x11,0x22,0xAA.
  - eng_done on an inactive engine during the partial batch has no effect.
- Backpressure: out_ready toggling 1,0,0,1,... -> no duplicated or lost beats; out_data/out_valid held during stalls; beat count per frame = W*H.
- Enable control: drop enable mid-frame -> frame completes, then IDLE with all outputs 0; hold enable=1 -> next frame restarts at (0,0) with out_sop.
- Reset during WAIT and during DRAIN -> next cycle all outputs 0, state IDLE; the following frame restarts at (0,0).
